ram_dp_sync: RTL and testbench

Parametrised synchronous simple-dual-port RAM: one write port, one registered read port, a global chip select, and a built-in clear sequencer that zeroes every word after reset or on request. It is the next generation of the team's asynchronous single-port RAM. It adds a clock, 1-cycle registered reads with a valid strobe, selectable read-during-write behaviour, and out-of-range address detection. It serves as the general storage primitive for register files and small buffers.

---
 rtl/ram_pkg.sv | 12 +
 rtl/ram_clr_ctrl.sv | 53 +++++
 rtl/ram_dp_sync.sv | 104 ++++++++++
 tb/tb_ram_dp_sync.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and types for the synchronous dual-port RAM family.
package ram_pkg;

  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_t;

endpackage

// File: rtl/ram_clr_ctrl.sv
// Clear sequencer: owns the RAM state, walks a pointer over every word and
// requests a zero write per cycle while busy.
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = 4,
  parameter int unsigned MEMORY_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  output logic                 clr_we,
  output logic [ADDR_SIZE-1:0] clr_addr,
  output logic                 busy
);

  localparam logic [ADDR_SIZE-1:0] LAST_WORD = ADDR_SIZE'(MEMORY_SIZE - 1);

  ram_state_t           state;
  logic [ADDR_SIZE-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          // clr is deliberately ignored here so a clear never restarts itself
          if (ptr == LAST_WORD) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
      endcase
    end
  end

  assign clr_we   = (state == CLEAR) && !rst;
  assign clr_addr = ptr;

endmodule

// File: rtl/ram_dp_sync.sv
// Synchronous simple-dual-port RAM with registered read, selectable
// read-during-write behaviour, range checking and a built-in clear sequence.
module ram_dp_sync
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_SIZE   = 4,
  parameter int unsigned WORD_SIZE   = 8,
  parameter int unsigned MEMORY_SIZE = 16,
  parameter int unsigned RD_MODE     = RD_FIRST
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic                 wr,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 rd,
  input  logic [ADDR_SIZE-1:0] raddr,
  input  logic                 clr,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 rd_valid,
  output logic                 err,
  output logic                 busy
);

  localparam logic [ADDR_SIZE:0] MEM_LIMIT = (ADDR_SIZE + 1)'(MEMORY_SIZE);

  logic [WORD_SIZE-1:0] mem [0:MEMORY_SIZE-1];

  logic                 clr_we;
  logic [ADDR_SIZE-1:0] clr_addr;

  logic                 access_en;
  logic                 wr_req;
  logic                 rd_req;
  logic                 w_in_range;
  logic                 r_in_range;
  logic                 wr_ok;
  logic                 bypass;
  logic [WORD_SIZE-1:0] rd_word;

  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [WORD_SIZE-1:0] mem_wdata;

  ram_clr_ctrl #(
    .ADDR_SIZE  (ADDR_SIZE),
    .MEMORY_SIZE(MEMORY_SIZE)
  ) u_clr_ctrl (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .busy    (busy)
  );

  always_comb begin
    access_en  = cs && !busy && !rst;
    wr_req     = access_en && wr;
    rd_req     = access_en && rd;
    w_in_range = {1'b0, waddr} < MEM_LIMIT;
    r_in_range = {1'b0, raddr} < MEM_LIMIT;
    wr_ok      = wr_req && w_in_range;
    bypass     = (RD_MODE == WR_FIRST) && wr_ok && (waddr == raddr);
    rd_word    = '0;
    if (r_in_range) begin
      rd_word = bypass ? data_in : mem[raddr];
    end
  end

  // Clear writes and user writes never overlap: user writes need !busy.
  always_comb begin
    mem_we    = wr_ok;
    mem_waddr = waddr;
    mem_wdata = data_in;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      err      <= (wr_req && !w_in_range) || (rd_req && !r_in_range);
      if (rd_req) begin
        data_out <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_ram_dp_sync.sv
// Bench for ram_dp_sync: three instances (read-first, write-first, 12-word)
// driven in lockstep and compared each cycle against an array-based model.
module tb_ram_dp_sync;

  localparam int NDUT = 3;

  logic                 clk = 1'b0;
  logic                 rst, cs, wr, rd, clr;
  logic [3:0]           waddr, raddr;
  logic [7:0]           data_in;
  logic [NDUT-1:0][7:0] dout;
  logic [NDUT-1:0]      valid, err, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_dp_sync #(.ADDR_SIZE(4), .WORD_SIZE(8), .MEMORY_SIZE(16), .RD_MODE(0)) dut_rf (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .waddr(waddr), .data_in(data_in),
    .rd(rd), .raddr(raddr), .clr(clr), .data_out(dout[0]), .rd_valid(valid[0]),
    .err(err[0]), .busy(busy[0]));

  ram_dp_sync #(.ADDR_SIZE(4), .WORD_SIZE(8), .MEMORY_SIZE(16), .RD_MODE(1)) dut_wf (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .waddr(waddr), .data_in(data_in),
    .rd(rd), .raddr(raddr), .clr(clr), .data_out(dout[1]), .rd_valid(valid[1]),
    .err(err[1]), .busy(busy[1]));

  ram_dp_sync #(.ADDR_SIZE(4), .WORD_SIZE(8), .MEMORY_SIZE(12), .RD_MODE(0)) dut_12 (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .waddr(waddr), .data_in(data_in),
    .rd(rd), .raddr(raddr), .clr(clr), .data_out(dout[2]), .rd_valid(valid[2]),
    .err(err[2]), .busy(busy[2]));

  function automatic int n_of(input int k);
    return (k == 2) ? 12 : 16;
  endfunction

  function automatic bit wf_of(input int k);
    return (k == 1);
  endfunction

  // Reference model: word array, remaining clear cycles, expected outputs
  logic [7:0] m_mem   [NDUT][16];
  int         m_left  [NDUT];
  logic [7:0] m_dout  [NDUT];
  logic       m_valid [NDUT];
  logic       m_err   [NDUT];

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NDUT; k++) begin
      int n;
      n = n_of(k);
      m_valid[k] = 1'b0;
      m_err[k]   = 1'b0;
      if (rst) begin
        m_left[k] = n;
        m_dout[k] = 8'h00;
      end else if (m_left[k] > 0) begin
        m_mem[k][n - m_left[k]] = 8'h00;
        m_left[k]--;
      end else begin
        if (cs && rd) begin
          m_valid[k] = 1'b1;
          if (int'(raddr) < n) begin
            if (wf_of(k) && wr && waddr == raddr) m_dout[k] = data_in;
            else m_dout[k] = m_mem[k][raddr];
          end else begin
            m_dout[k] = 8'h00;
            m_err[k]  = 1'b1;
          end
        end
        if (cs && wr) begin
          if (int'(waddr) < n) m_mem[k][waddr] = data_in;
          else m_err[k] = 1'b1;
        end
        if (clr) m_left[k] = n;
      end
    end
  endtask

  task automatic compare_model();
    for (int k = 0; k < NDUT; k++) begin
      check("busy", k, busy[k], m_left[k] > 0);
      check("rd_valid", k, valid[k], m_valid[k]);
      check("err", k, err[k], m_err[k]);
      check("data_out", k, dout[k], m_dout[k]);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic w, input logic [3:0] wa,
                      input logic [7:0] d, input logic rv, input logic [3:0] ra,
                      input logic cl);
    rst = r; cs = c; wr = w; waddr = wa; data_in = d; rd = rv; raddr = ra; clr = cl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  // Counts busy samples from the current one on, issuing a read every cycle;
  // a read issued while busy must never produce rd_valid.
  task automatic busy_run(input string name);
    int              cnt [NDUT];
    logic [NDUT-1:0] was_busy;
    for (int k = 0; k < NDUT; k++) cnt[k] = int'(busy[k]);
    for (int i = 0; i < 24; i++) begin
      was_busy = busy;
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'($urandom_range(15)), 1'b0);
      for (int k = 0; k < NDUT; k++) begin
        if (busy[k]) cnt[k]++;
        if (was_busy[k]) check({name, "_rd_blocked"}, k, valid[k], 1'b0);
      end
    end
    for (int k = 0; k < NDUT; k++) check({name, "_busy_len"}, k, cnt[k], n_of(k));
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0);
      check({name, "_valid"}, 0, valid[0], 1'b1);
      check({name, "_zero"}, 0, dout[0], 8'h00);
    end
  endtask

  task automatic rand_phase(input int cycles);
    logic r, c, w, rv, cl;
    for (int i = 0; i < cycles; i++) begin
      r  = ($urandom_range(199) == 0);
      cl = ($urandom_range(59) == 0);
      c  = ($urandom_range(99) < 85);
      w  = 1'($urandom_range(1));
      rv = 1'($urandom_range(1));
      step(r, c, w, 4'($urandom_range(15)), 8'($urandom_range(255)), rv,
           4'($urandom_range(15)), cl);
    end
  endtask

  typedef struct {
    logic       cs;
    logic       wr;
    logic [3:0] waddr;
    logic [7:0] din;
    logic       rd;
    logic [3:0] raddr;
    logic       exp_valid;
    logic [7:0] exp_rf;
    logic [7:0] exp_wf;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 4'd3,  8'hA5, 1'b0, 4'd0,  1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  1'b1, 8'hA5, 8'hA5};
    vecs[2] = '{1'b0, 1'b1, 4'd4,  8'h5A, 1'b1, 4'd3,  1'b0, 8'hA5, 8'hA5};
    vecs[3] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd4,  1'b1, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 4'd5,  8'h11, 1'b0, 4'd0,  1'b0, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b1, 4'd5,  8'h22, 1'b1, 4'd5,  1'b1, 8'h11, 8'h22};
    vecs[6] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd5,  1'b1, 8'h22, 8'h22};
    vecs[7] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 1'b1, 8'h00, 8'h00};
    vecs[8] = '{1'b1, 1'b1, 4'd15, 8'h77, 1'b1, 4'd15, 1'b1, 8'h00, 8'h77};
    vecs[9] = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b0, 4'd0,  1'b0, 8'h00, 8'h77};

    for (int k = 0; k < NDUT; k++) begin
      m_left[k] = 0;
      for (int a = 0; a < 16; a++) m_mem[k][a] = 8'h00;
    end

    // Reset, then the clear must last exactly MEMORY_SIZE cycles
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < NDUT; k++) begin
      check("reset_busy", k, busy[k], 1'b1);
      check("reset_data", k, dout[k], 8'h00);
      check("reset_valid", k, valid[k], 1'b0);
    end
    busy_run("reset_clear");
    read_all_zero("post_reset");

    // Directed write/read and read-during-write vectors
    for (int i = 0; i < 10; i++) begin
      step(1'b0, vecs[i].cs, vecs[i].wr, vecs[i].waddr, vecs[i].din, vecs[i].rd,
           vecs[i].raddr, 1'b0);
      check("vec_valid_rf", i, valid[0], vecs[i].exp_valid);
      check("vec_data_rf", i, dout[0], vecs[i].exp_rf);
      check("vec_valid_wf", i, valid[1], vecs[i].exp_valid);
      check("vec_data_wf", i, dout[1], vecs[i].exp_wf);
      check("vec_err", i, err[0], 1'b0);
    end

    // Out-of-range write and read on the 12-word instance
    step(1'b0, 1'b1, 1'b1, 4'd13, 8'hEE, 1'b1, 4'd14, 1'b0);
    check("range_err", 2, err[2], 1'b1);
    check("range_valid", 2, valid[2], 1'b1);
    check("range_data", 2, dout[2], 8'h00);
    for (int a = 0; a < 12; a++) step(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'(a), 1'b0);

    // Fill with 0xFF, clear on request, verify zeroes
    for (int a = 0; a < 16; a++) step(1'b0, 1'b1, 1'b1, 4'(a), 8'hFF, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1);
    check("clr_access_valid", 0, valid[0], 1'b1);
    check("clr_access_data", 0, dout[0], 8'hFF);
    busy_run("clr_clear");
    read_all_zero("post_clr");

    // Reset at clear cycle 7 restarts the whole clear
    step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    check("mid_clear_busy", 0, busy[0], 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0);
    busy_run("restart_clear");

    rand_phase(1500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
